// File: rtl/cotm32_pipeline_pkg.sv
// Shared constants and types for cotm32 pipeline stage boundaries.
package cotm32_pipeline_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_occ_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Parametrised valid/ready pipeline stage register, optional two-entry skid,
// flush with NOP injection, occupancy and saturating back-pressure counter.
module pipe_skid_reg
  import cotm32_pipeline_pkg::*;
#(
  parameter int unsigned          DATA_W   = 32,
  parameter logic [DATA_W-1:0]    NOP_DATA = DATA_W'(INST_NOP),
  parameter bit                   SKID     = 1'b1,
  parameter int unsigned          CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_bp_cnt
);

  logic              valid_w;
  logic              ready_w;
  logic [DATA_W-1:0] data_w;
  logic [1:0]        occ_w;

  if (SKID) begin : g_skid
    pipe_occ_e         occ_q, occ_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              ready_q;
    logic              push, pop;

    assign push = i_valid && ready_q;
    assign pop  = (occ_q != EMPTY) && i_ready;

    always_comb begin
      occ_d  = occ_q;
      main_d = main_q;
      skid_d = skid_q;
      unique case (occ_q)
        EMPTY: begin
          if (push) begin
            occ_d  = ONE;
            main_d = i_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = i_data;
          end else if (push) begin
            occ_d  = TWO;
            skid_d = i_data;
          end else if (pop) begin
            occ_d  = EMPTY;
            main_d = NOP_DATA;
          end
        end
        TWO: begin
          if (pop) begin
            occ_d  = ONE;
            main_d = skid_q;
            skid_d = NOP_DATA;
          end
        end
        default: begin
          occ_d  = EMPTY;
          main_d = NOP_DATA;
          skid_d = NOP_DATA;
        end
      endcase
    end

    // ready is registered from the next state so i_ready never reaches o_ready
    always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
        occ_q   <= EMPTY;
        main_q  <= NOP_DATA;
        skid_q  <= NOP_DATA;
        ready_q <= 1'b1;
      end else begin
        occ_q   <= occ_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        ready_q <= (occ_d != TWO);
      end
    end

    assign valid_w = (occ_q != EMPTY);
    assign ready_w = ready_q;
    assign data_w  = main_q;
    assign occ_w   = occ_q;
  end else begin : g_single
    logic              valid_q;
    logic [DATA_W-1:0] main_q;
    logic              push, pop;

    assign ready_w = !valid_q || i_ready;
    assign push    = i_valid && ready_w;
    assign pop     = valid_q && i_ready;

    always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
        valid_q <= 1'b0;
        main_q  <= NOP_DATA;
      end else if (push) begin
        valid_q <= 1'b1;
        main_q  <= i_data;
      end else if (pop) begin
        valid_q <= 1'b0;
        main_q  <= NOP_DATA;
      end
    end

    assign valid_w = valid_q;
    assign data_w  = main_q;
    assign occ_w   = valid_q ? ONE : EMPTY;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_bp_cnt (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .inc_i   (valid_w && !i_ready),
    .count_o (o_bp_cnt)
  );

  assign o_valid     = valid_w;
  assign o_ready     = ready_w;
  assign o_data      = data_w;
  assign o_occupancy = occ_w;

endmodule
